// File: rtl/choose_ctrl.sv
// choose_ctrl
//   Sequencing controller for the Choose selection datapath. Six operands
//   arrive serially, one per accepted beat, plus a mode sampled on beat 0.
//   They are held as registered operands for one evaluation cycle. The
//   combinational Choose result is then captured into a small FIFO and
//   released to the consumer under a valid/ready handshake.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand beat handshake
//   in_mode, in_data     batch mode (beat 0 only) and operand data
//   ch_mode, ch_n0..5    registered operands to the Choose instance
//   ch_out               combinational Choose result
//   out_valid/out_ready  result handshake, out_data is the FIFO head
//   busy                 a batch is being loaded or evaluated
module choose_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_mode,
  input  logic [9:0] in_data,
  output logic       in_ready,
  output logic [1:0] ch_mode,
  output logic [9:0] ch_n0,
  output logic [9:0] ch_n1,
  output logic [9:0] ch_n2,
  output logic [9:0] ch_n3,
  output logic [9:0] ch_n4,
  output logic [9:0] ch_n5,
  input  logic [9:0] ch_out,
  output logic       out_valid,
  output logic [9:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  localparam int DATA_W = 10;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL
  } state_t;

  state_t              r_state;
  logic [2:0]          r_beat;
  logic [1:0]          r_mode;
  logic [DATA_W-1:0]   r_n   [0:5];
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;

  logic w_in_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_out_valid;

  // The IDLE gate reserves a FIFO slot for the batch it starts; it looks at
  // the registered count only, so a same-cycle pop does not open it early.
  always_comb begin
    w_in_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE:  w_in_ready = (r_count < C_DEPTH);
        S_LOAD:  w_in_ready = 1'b1;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept    = in_valid & w_in_ready;
  assign w_push      = (r_state == S_EVAL);
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= 3'd0;
      r_mode  <= 2'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < 6; i++) r_n[i] <= '0;
      // Cleared so a reset never leaves a stale result visible on out_data.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n[0]  <= in_data;
            r_mode  <= in_mode;
            r_beat  <= 3'd1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Bubbles (in_valid low) simply hold everything.
          if (w_accept) begin
            r_n[r_beat] <= in_data;
            if (r_beat == 3'd5) begin
              r_beat  <= 3'd0;
              r_state <= S_EVAL;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        S_EVAL: begin
          // Operands have been stable all cycle; capture Choose's answer.
          r_mem[r_wptr] <= ch_out;
          r_wptr        <= r_wptr + 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) r_rptr <= r_rptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign ch_mode   = r_mode;
  assign ch_n0     = r_n[0];
  assign ch_n1     = r_n[1];
  assign ch_n2     = r_n[2];
  assign ch_n3     = r_n[3];
  assign ch_n4     = r_n[4];
  assign ch_n5     = r_n[5];
  assign out_valid = w_out_valid;
  assign out_data  = r_mem[r_rptr];
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_choose_ctrl.sv
// tb_choose_ctrl
//   Directed bench for choose_ctrl. A stand-in for Choose selects operand
//   n0..n3 by mode. Inputs are driven just after the falling edge and
//   outputs are sampled at the falling edge, away from the active edge.
module tb_choose_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_mode;
  logic [9:0] in_data;
  logic       in_ready;
  logic [1:0] ch_mode;
  logic [9:0] ch_n0, ch_n1, ch_n2, ch_n3, ch_n4, ch_n5;
  logic [9:0] ch_out;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [5:0][9:0] OPS_A = {10'd4, 10'd1, 10'd11, 10'd3, 10'd30, 10'd14};
  localparam logic [5:0][9:0] OPS_B = {10'd10, 10'd9, 10'd8, 10'd7, 10'd6, 10'd5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Choose stand-in
  always_comb begin
    case (ch_mode)
      2'd0:    ch_out = ch_n0;
      2'd1:    ch_out = ch_n1;
      2'd2:    ch_out = ch_n2;
      default: ch_out = ch_n3;
    endcase
  end

  choose_ctrl #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ch_mode  (ch_mode),
    .ch_n0    (ch_n0),
    .ch_n1    (ch_n1),
    .ch_n2    (ch_n2),
    .ch_n3    (ch_n3),
    .ch_n4    (ch_n4),
    .ch_n5    (ch_n5),
    .ch_out   (ch_out),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // All tasks start and end just after a falling edge.
  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0; in_data = 10'd0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [9:0] d, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_mode = m;
    #1;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_batch(input logic [5:0][9:0] ops, input logic [1:0] m);
    for (int i = 0; i < 6; i++) send_beat(ops[i], m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0; in_data = 10'd0;
    @(posedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low: got %0b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
    checks++; if (out_data !== 10'd0) begin errors++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
    checks++;
    if ({ch_mode, ch_n0, ch_n1, ch_n2, ch_n3, ch_n4, ch_n5} !== 62'd0) begin
      errors++; $display("FAIL rst_ch_regs: got %h required 0", {ch_mode, ch_n0, ch_n1, ch_n2, ch_n3, ch_n4, ch_n5});
    end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_basic();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send_beat(OPS_A[i], 2'd2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_beat%0d: got %0b required 1", i, busy); end
    end
    // Now in EVAL: result not yet visible
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_eval: got %0b required 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_eval: got %0b required 0", in_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %0b required 0", busy); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b required 1", out_valid); end
    checks++; if (out_data !== 10'd3) begin errors++; $display("FAIL basic_out_data: got %0d required 3", out_data); end
    checks++;
    if ({ch_n0, ch_n1, ch_n2, ch_n3, ch_n4, ch_n5} !== {10'd14, 10'd30, 10'd3, 10'd11, 10'd1, 10'd4}) begin
      errors++; $display("FAIL basic_ch_regs: got %0d,%0d,%0d,%0d,%0d,%0d required 14,30,3,11,1,4",
                         ch_n0, ch_n1, ch_n2, ch_n3, ch_n4, ch_n5);
    end
    checks++; if (ch_mode !== 2'd2) begin errors++; $display("FAIL basic_ch_mode: got %0d required 2", ch_mode); end
  endtask

  task automatic test_all_modes();
    logic [9:0] exp_v [4];
    int start_cyc [4];
    exp_v[0] = 10'd14; exp_v[1] = 10'd30; exp_v[2] = 10'd3; exp_v[3] = 10'd11;
    apply_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      start_cyc[b] = cyc;
      send_batch(OPS_A, 2'(b));
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL modes_in_ready_eval%0d: got %0b required 0", b, in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL modes_in_ready_idle%0d: got %0b required 1", b, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v[b]) begin
        errors++; $display("FAIL modes_result%0d: got valid=%0b data=%0d required valid=1 data=%0d", b, out_valid, out_data, exp_v[b]);
      end
      if (b > 0) begin
        checks++;
        if (start_cyc[b] - start_cyc[b-1] != 7) begin
          errors++; $display("FAIL modes_spacing%0d: got %0d cycles required 7", b, start_cyc[b] - start_cyc[b-1]);
        end
      end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modes_drained: got %0b required 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_bubbles();
    apply_reset();
    for (int i = 0; i < 3; i++) send_beat(OPS_A[i], 2'd1);
    for (int i = 0; i < 3; i++) begin
      in_mode = 2'd3;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || ch_n3 !== 10'd0) begin
        errors++; $display("FAIL bubble_hold%0d: got busy=%0b in_ready=%0b ch_n3=%0d required 1,1,0", i, busy, in_ready, ch_n3);
      end
    end
    for (int i = 3; i < 6; i++) send_beat(OPS_A[i], 2'd3);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 10'd30) begin
      errors++; $display("FAIL bubble_result: got valid=%0b data=%0d required valid=1 data=30", out_valid, out_data);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp_v [4];
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      send_batch(OPS_A, 2'(b));
      @(negedge clk);
    end
    checks++; if (out_data !== 10'd14) begin errors++; $display("FAIL bp_head: got %0d required 14", out_data); end
    // Offer beat 0 of batch 5 while the FIFO is full
    in_valid = 1'b1; in_data = OPS_B[0]; in_mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL bp_blocked%0d: got in_ready=%0b busy=%0b required 0,0", i, in_ready, busy);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_bypass: got in_ready=%0b required 0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_not_accepted: got busy=%0b required 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got in_ready=%0b required 1", in_ready); end
    send_batch(OPS_B, 2'd2);
    @(negedge clk);
    exp_v[0] = 10'd30; exp_v[1] = 10'd3; exp_v[2] = 10'd11; exp_v[3] = 10'd7;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v[i]) begin
        errors++; $display("FAIL bp_pop%0d: got valid=%0b data=%0d required valid=1 data=%0d", i, out_valid, out_data, exp_v[i]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b required 0", out_valid); end
  endtask

  task automatic test_push_pop();
    apply_reset();
    send_batch(OPS_A, 2'd0);
    @(negedge clk);
    send_batch(OPS_A, 2'd1);
    // EVAL cycle: head still the first result
    checks++; if (out_data !== 10'd14) begin errors++; $display("FAIL pp_head_before: got %0d required 14", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 10'd30) begin
      errors++; $display("FAIL pp_new_head: got valid=%0b data=%0d required valid=1 data=30", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_count_one: got valid=%0b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_batch(OPS_A, 2'd0);
    @(negedge clk);
    send_batch(OPS_A, 2'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_beat(OPS_B[i], 2'd3);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready_low: got %0b required 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 10'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_outputs: got valid=%0b data=%0d busy=%0b in_ready=%0b required 0,0,0,1",
                         out_valid, out_data, busy, in_ready);
    end
    checks++;
    if ({ch_mode, ch_n0, ch_n1, ch_n2, ch_n3, ch_n4, ch_n5} !== 62'd0) begin
      errors++; $display("FAIL mid_ch_regs: got %h required 0", {ch_mode, ch_n0, ch_n1, ch_n2, ch_n3, ch_n4, ch_n5});
    end
    send_batch(OPS_B, 2'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 10'd5) begin
      errors++; $display("FAIL mid_new_result: got valid=%0b data=%0d required valid=1 data=5", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got valid=%0b required 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_modes();
    test_bubbles();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
